fifo_lvl: RTL and testbench
===========================

Name: fifo_lvl

Overview:
Synchronous show-ahead FIFO with an occupancy counter, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Drop-in successor for the UART RX/TX buffers.
- Lets the UART and game-logic blocks throttle on a level instead of only on hard full/empty, and detect lost bytes.
- Single clock domain.

Parameters:
- B, 8, data word width in bits.
- W, 4, address width; depth D = 2**W words.
- AF_LVL, 2**W-2, almost_full asserts when count >= AF_LVL; legal range 1..D.
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL; legal range 0..D-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, highest priority.
- wr  in  1  write request.
- w_data  in  B  write data.
- rd  in  1  read request; pops the word shown on r_data.
- r_data  out  B  head-of-queue word (show-ahead).
- empty  out  1  count == 0.
- full  out  1  count == D.
- almost_empty  out  1  count <= AE_LVL.
- almost_full  out  1  count >= AF_LVL.
- count  out  W+1  current occupancy, 0..D.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read hit an empty FIFO.

Behaviour:
- Reset: rst_n low asynchronously forces the following; memory is not reset.
  - w_ptr = r_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (0 unless AF_LVL = 0, which is illegal).
  - overflow = underflow = 0.
- Reset release is synchronous to clk. The first wr is accepted on the first rising edge with rst_n high.
- State: w_ptr and r_ptr are W bits each and wrap modulo D naturally. count is W+1 bits.
- Flag derivation: all status outputs are combinational decodes of registered count, so they are glitch-free and update in the cycle after the causing edge.
- Read data path:
  - r_data = mem[r_ptr] combinationally; zero-latency show-ahead.
  - A word written at edge N is visible on r_data after edge N when the FIFO was empty.
  - r_data is don't-care while empty.
- Write accept: wr_ok = wr & (~full | rd_ok).
  - A write into a full FIFO is accepted only when a read pops in the same cycle.
  - On accept: mem[w_ptr] <= w_data, then w_ptr++.
- Read accept: rd_ok = rd & ~empty. On accept: r_ptr++.
- Count update per edge: count + wr_ok - rd_ok.
- Simultaneous rd and wr:
  - Empty: write accepted, read rejected, underflow set; count 0 -> 1.
  - Full: both accepted, count stays D, no overflow.
  - Otherwise: both accepted, count unchanged.
- Error flags:
  - overflow <= 1 when wr & ~wr_ok.
  - underflow <= 1 when rd & empty.
  - Both hold until clr or reset. Rejected operations change no pointer or count.
- clr high at an edge, regardless of wr/rd:
  - Pointers and count go to 0; overflow and underflow clear.
  - A same-cycle wr is discarded and does not set overflow.
  - Memory contents are left untouched.
- Wrap-around: pointers roll from D-1 to 0 without special handling. full/empty come from count, never from pointer equality.
- Thresholds are static parameters. No runtime programming.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with count=5 -> immediately count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
- Fill/drain, B=8 W=4: write 0x00..0x0F -> full=1 and almost_full=1 from count 14; a 17th write is dropped, overflow=1, count=16. Read 16 -> r_data sequence 0x00..0x0F, empty=1.
- Wrap: write 10, read 10, write 12 (0xA0..0xAB), read 12 -> data in order across the pointer wrap, count returns to 0, no error flags.
- Simultaneous: on full, rd=wr=1 with w_data=0x55 -> count stays 16, overflow=0, 0x55 emerges last. On empty, rd=wr=1 with 0x33 -> count=1, r_data=0x33, underflow=1.
- Thresholds, AE_LVL=1 AF_LVL=14: step count 0->16->0 -> almost_empty high exactly for count <=1, almost_full high exactly for count >=14.
- Flush: count=7, overflow=1, clr=1 with wr=1 -> next cycle count=0, empty=1, overflow=0, and the written word is absent.

Source files
------------

// File: rtl/fifo_lvl.sv
// -----------------------------------------------------------------------------
// fifo_lvl : single-clock show-ahead FIFO with occupancy counter, static
//            almost-full / almost-empty thresholds, synchronous flush and
//            sticky overflow / underflow error flags.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (pointers, count, error flags)
//   clr           synchronous flush, overrides wr/rd in the same cycle
//   wr, w_data    write request and data
//   rd            read request; pops the word currently shown on r_data
//   r_data        head-of-queue word (valid whenever empty is low)
//   empty, full   count == 0 / count == D
//   almost_empty  count <= AE_LVL
//   almost_full   count >= AF_LVL
//   count         occupancy 0..D
//   overflow      sticky: a write was dropped
//   underflow     sticky: a read hit an empty FIFO
// -----------------------------------------------------------------------------
module fifo_lvl #(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AF_LVL = 2**W - 2,
    parameter int AE_LVL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int         D       = 2**W;
    localparam logic [W:0] DEPTH_C = (W+1)'(D);
    localparam logic [W:0] AF_C    = (W+1)'(AF_LVL);
    localparam logic [W:0] AE_C    = (W+1)'(AE_LVL);
    localparam logic [W:0] ONE_C   = {{W{1'b0}}, 1'b1};

    logic [B-1:0] mem_r [D];
    logic [W-1:0] w_ptr_r;
    logic [W-1:0] r_ptr_r;
    logic [W:0]   count_r;
    logic         overflow_r;
    logic         underflow_r;

    logic         empty_s;
    logic         full_s;
    logic         rd_ok_s;
    logic         wr_ok_s;
    logic [W:0]   count_nxt_s;

    // Status decodes come from the registered count only, so they never glitch.
    assign empty_s = (count_r == {(W+1){1'b0}});
    assign full_s  = (count_r == DEPTH_C);

    // A full FIFO can still take a write when a read frees a slot on the same edge.
    assign rd_ok_s = rd & ~empty_s;
    assign wr_ok_s = wr & (~full_s | rd_ok_s);

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and sticky error flags; clr flushes ahead of any request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_r     <= {W{1'b0}};
            r_ptr_r     <= {W{1'b0}};
            count_r     <= {(W+1){1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clr) begin
            w_ptr_r     <= {W{1'b0}};
            r_ptr_r     <= {W{1'b0}};
            count_r     <= {(W+1){1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                w_ptr_r <= w_ptr_r + {{(W-1){1'b0}}, 1'b1};
            end else begin
                w_ptr_r <= w_ptr_r;
            end
            if (rd_ok_s) begin
                r_ptr_r <= r_ptr_r + {{(W-1){1'b0}}, 1'b1};
            end else begin
                r_ptr_r <= r_ptr_r;
            end
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_r  | (wr & ~wr_ok_s);
            underflow_r <= underflow_r | (rd & empty_s);
        end
    end

    // Storage array: not reset, and a flushed write must not land in memory.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !clr) begin
            mem_r[w_ptr_r] <= w_data;
        end
    end

    assign r_data       = mem_r[r_ptr_r];
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_r <= AE_C);
    assign almost_full  = (count_r >= AF_C);
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_lvl.sv
// -----------------------------------------------------------------------------
// tb_fifo_lvl : directed self-checking bench for fifo_lvl (B=8, W=4,
//               AF_LVL=14, AE_LVL=1). Inputs change and outputs are sampled
//               1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_lvl;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    fifo_lvl #(.B(8), .W(4), .AF_LVL(14), .AE_LVL(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count plus every status decode expected at occupancy n.
    task automatic chk_lvl(input string tag, input int n);
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), (n == 0) ? 32'd1 : 32'd0);
        chk({tag, ".full"}, 32'(full), (n == 16) ? 32'd1 : 32'd0);
        chk({tag, ".almost_empty"}, 32'(almost_empty), (n <= 1) ? 32'd1 : 32'd0);
        chk({tag, ".almost_full"}, 32'(almost_full), (n >= 14) ? 32'd1 : 32'd0);
    endtask

    // One clock cycle with the given request pattern, then inputs return idle.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr     = w;
        rd     = r;
        w_data = d;
        clr    = c;
        @(posedge clk);
        #1;
        wr     = 1'b0;
        rd     = 1'b0;
        clr    = 1'b0;
        w_data = 8'h00;
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = 8'h00;

        // ---- reset state ----
        #12;
        chk_lvl("reset", 0);
        chk("reset.overflow", 32'(overflow), 32'd0);
        chk("reset.underflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- fill 0x00..0x0F, thresholds on the way up ----
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
            chk_lvl("fill", i + 1);
        end
        chk("fill.overflow", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b0, 8'hEE, 1'b0);
        chk_lvl("ovf", 16);
        chk("ovf.overflow", 32'(overflow), 32'd1);

        // ---- drain, data order and thresholds on the way down ----
        for (int i = 0; i < 16; i++) begin
            chk("drain.r_data", 32'(r_data), 32'(i));
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk_lvl("drain", 15 - i);
        end
        chk("drain.underflow", 32'(underflow), 32'd0);
        chk("drain.overflow_sticky", 32'(overflow), 32'd1);

        // ---- clear error state, then wrap-around ----
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr.overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        chk_lvl("wrap10", 10);
        for (int i = 0; i < 10; i++) begin
            chk("wrap10.r_data", 32'(r_data), 32'(8'h10 + i));
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
        end
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        chk_lvl("wrap12", 12);
        for (int i = 0; i < 12; i++) begin
            chk("wrap12.r_data", 32'(r_data), 32'(8'hA0 + i));
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
        end
        chk_lvl("wrap.end", 0);
        chk("wrap.overflow", 32'(overflow), 32'd0);
        chk("wrap.underflow", 32'(underflow), 32'd0);

        // ---- simultaneous rd/wr on a full FIFO ----
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        chk_lvl("simfull.pre", 16);
        cyc(1'b1, 1'b1, 8'h55, 1'b0);
        chk_lvl("simfull", 16);
        chk("simfull.overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("simfull.r_data", 32'(r_data), (i < 15) ? 32'(8'h61 + i) : 32'h55);
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
        end
        chk_lvl("simfull.end", 0);
        chk("simfull.underflow", 32'(underflow), 32'd0);

        // ---- simultaneous rd/wr on an empty FIFO ----
        cyc(1'b1, 1'b1, 8'h33, 1'b0);
        chk_lvl("simempty", 1);
        chk("simempty.r_data", 32'(r_data), 32'h33);
        chk("simempty.underflow", 32'(underflow), 32'd1);
        cyc(1'b1, 1'b0, 8'h34, 1'b0);
        chk("simempty.underflow_sticky", 32'(underflow), 32'd1);
        chk("simempty.head", 32'(r_data), 32'h33);

        // ---- flush with count=7, overflow=1 and a same-cycle write ----
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk_lvl("flush0", 0);
        chk("flush0.underflow", 32'(underflow), 32'd0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk_lvl("flush.pre", 7);
        chk("flush.pre.overflow", 32'(overflow), 32'd1);
        cyc(1'b1, 1'b0, 8'hCC, 1'b1);
        chk_lvl("flush", 0);
        chk("flush.overflow", 32'(overflow), 32'd0);
        chk("flush.underflow", 32'(underflow), 32'd0);
        cyc(1'b1, 1'b0, 8'h44, 1'b0);
        chk_lvl("flush.post", 1);
        chk("flush.post.r_data", 32'(r_data), 32'h44);

        // ---- asynchronous reset mid-stream at count=5 ----
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h95, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk_lvl("midrst.pre", 16);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk_lvl("midrst.pre5", 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk_lvl("midrst", 0);
        chk("midrst.overflow", 32'(overflow), 32'd0);
        chk("midrst.underflow", 32'(underflow), 32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 8'h5A, 1'b0);
        chk_lvl("postrst", 1);
        chk("postrst.r_data", 32'(r_data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
